// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, MEM-stage FSM encoding and default timeout.
package cpu_pkg;

    localparam int unsigned DATA_W         = 16;
    localparam int unsigned REG_ADDR_W     = 3;
    localparam int unsigned TIMEOUT_CYCLES = 255;

    typedef enum logic {
        StIdle   = 1'b0,
        StAccess = 1'b1
    } state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter for a memory handshake, with clear/enable and an expired flag.
// The expired flag is raised during the enabled cycle that brings the count to LIMIT,
// so a caller aborting on it keeps its request up for exactly LIMIT cycles.
// LIMIT is expected to be at least 1.
module mem_wait_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    import cpu_pkg::*;

    localparam int unsigned CntW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [CntW-1:0] count;

    // Count enabled cycles, holding at LIMIT rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count <= '0;
        end else if (enable && (count != CntW'(LIMIT))) begin
            count <= count + CntW'(1);
        end
    end

    // Combinational so the abort lands on the same edge the count reaches LIMIT.
    always_comb begin
        expired = enable && (count >= CntW'(LIMIT - 1));
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage controller: drives the data memory through req/ack, resolves branches and
// registers results toward the MEM/WB boundary. Stalls upstream while an access is open.
module mem_access_stage #(
    parameter int unsigned DATA_W         = cpu_pkg::DATA_W,
    parameter int unsigned REG_ADDR_W     = cpu_pkg::REG_ADDR_W,
    parameter int unsigned TIMEOUT_CYCLES = cpu_pkg::TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     ALU_Result_in,
    input  logic                  Zero_in,
    input  logic [DATA_W-1:0]     adder_result_in,
    input  logic [DATA_W-1:0]     read_data_2_in,
    input  logic [REG_ADDR_W-1:0] mux_rd_rt_in,
    input  logic                  MemToReg_in,
    input  logic                  RegWrite_in,
    input  logic                  MemRead_in,
    input  logic                  MemWrite_in,
    input  logic                  Branch_in,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  stall,
    output logic                  PCSrc,
    output logic [DATA_W-1:0]     branch_target,
    output logic                  wb_valid,
    output logic [DATA_W-1:0]     read_data_out,
    output logic [DATA_W-1:0]     ALU_Result_out,
    output logic [REG_ADDR_W-1:0] mux_rd_rt_out,
    output logic                  MemToReg_out,
    output logic                  RegWrite_out,
    output logic                  mem_err
);

    import cpu_pkg::*;

    state_e state;
    logic   mem_op;
    logic   both_ops;
    logic   timer_clr;
    logic   timer_en;
    logic   timer_expired;

    // Decode the incoming slot and the handshake-derived control strobes.
    always_comb begin
        mem_op    = MemRead_in | MemWrite_in;
        both_ops  = MemRead_in & MemWrite_in;
        timer_clr = (state == StIdle) & in_valid & mem_op;
        timer_en  = (state == StAccess) & ~mem_ack;
        // Held low in reset so upstream is never frozen by a stale ACCESS state.
        stall     = rst_n & (state == StAccess) & ~mem_ack;
    end

    mem_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clr),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    // FSM with registered memory, branch and WB outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= StIdle;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            PCSrc          <= 1'b0;
            branch_target  <= '0;
            wb_valid       <= 1'b0;
            read_data_out  <= '0;
            ALU_Result_out <= '0;
            mux_rd_rt_out  <= '0;
            MemToReg_out   <= 1'b0;
            RegWrite_out   <= 1'b0;
            mem_err        <= 1'b0;
        end else begin
            PCSrc <= 1'b0;
            unique case (state)
                StIdle: begin
                    wb_valid <= 1'b0;
                    if (in_valid) begin
                        ALU_Result_out <= ALU_Result_in;
                        mux_rd_rt_out  <= mux_rd_rt_in;
                        MemToReg_out   <= MemToReg_in;
                        read_data_out  <= '0;
                        if (Branch_in && Zero_in) begin
                            PCSrc         <= 1'b1;
                            branch_target <= adder_result_in;
                        end
                        if (mem_op) begin
                            mem_req      <= 1'b1;
                            mem_we       <= MemWrite_in;
                            mem_addr     <= ALU_Result_in;
                            mem_wdata    <= read_data_2_in;
                            // Read+write collides: do the write, never write back.
                            RegWrite_out <= RegWrite_in & ~both_ops;
                            if (both_ops) begin
                                mem_err <= 1'b1;
                            end
                            state <= StAccess;
                        end else begin
                            RegWrite_out <= RegWrite_in;
                            wb_valid     <= 1'b1;
                        end
                    end
                end
                StAccess: begin
                    if (mem_ack) begin
                        mem_req       <= 1'b0;
                        read_data_out <= mem_we ? '0 : mem_rdata;
                        wb_valid      <= 1'b1;
                        state         <= StIdle;
                    end else if (timer_expired) begin
                        // Give up: retire the slot without a register write.
                        mem_req       <= 1'b0;
                        mem_err       <= 1'b1;
                        RegWrite_out  <= 1'b0;
                        read_data_out <= '0;
                        wb_valid      <= 1'b1;
                        state         <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage controller that consumes the EX/MEM pipeline register outputs and drives the single-port data memory through a req/ack handshake.
- Resolves branches by generating PCSrc and the branch target.
- Raises `stall` while a memory access is outstanding.
- Registers results toward the MEM/WB boundary.
- Sits between ex_mem_register and the WB stage; multi-cycle memory latency is tolerated.

Parameters:
- DATA_W, 16, datapath / address width
- REG_ADDR_W, 3, destination register index width
- TIMEOUT_CYCLES, 255, maximum cycles waiting for mem_ack before abort

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  EX/MEM slot holds a real instruction
- ALU_Result_in  in  DATA_W  memory address / ALU result
- Zero_in  in  1  ALU zero flag
- adder_result_in  in  DATA_W  branch target
- read_data_2_in  in  DATA_W  store data
- mux_rd_rt_in  in  REG_ADDR_W  destination register
- MemToReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in  in  1 each  control bits
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  DATA_W  memory address
- mem_wdata  out  DATA_W  write data
- mem_ack  in  1  memory completion
- mem_rdata  in  DATA_W  read data, valid with mem_ack
- stall  out  1  hold upstream pipeline
- PCSrc  out  1  branch taken
- branch_target  out  DATA_W  taken-branch PC
- wb_valid  out  1  WB outputs carry a completed instruction
- read_data_out, ALU_Result_out  out  DATA_W  WB data
- mux_rd_rt_out  out  REG_ADDR_W  WB destination
- MemToReg_out, RegWrite_out  out  1  WB controls
- mem_err  out  1  sticky error flag

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous, active-low, on rst_n.
  - While rst_n = 0 at a rising edge, every output register goes to 0, state goes to IDLE, and the wait counter goes to 0.
  - Reset during ACCESS drops mem_req at that edge; a late mem_ack is ignored.
- FSM states: IDLE, ACCESS.
- IDLE, in_valid = 0:
  - wb_valid = 0 and PCSrc = 0 next cycle.
- IDLE, in_valid = 1, no memory op:
  - All inputs are registered to WB outputs; wb_valid = 1 next cycle (latency 1).
  - read_data_out = 0.
- IDLE, in_valid = 1, MemRead or MemWrite:
  - Latch address, wdata, destination and controls.
  - mem_req = 1, mem_we = MemWrite_in, state goes to ACCESS.
  - wb_valid = 0 next cycle.
- MemRead and MemWrite both set:
  - Performed as a write with RegWrite forced to 0.
  - mem_err is set.
- ACCESS:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable; stall = 1.
  - in_valid is ignored (upstream holds).
  - On mem_ack: mem_req = 0, read_data_out captures mem_rdata (reads) or 0 (writes), wb_valid = 1 for one cycle, state goes to IDLE.
  - mem_ack may arrive in the first ACCESS cycle.
- stall:
  - stall is combinational: `stall = (state == ACCESS) & ~mem_ack`.
  - stall is also 0 during reset.
- Timeout:
  - The wait counter increments each ACCESS cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES: mem_req = 0, mem_err is set, and wb_valid = 1 with RegWrite_out = 0.
  - State returns to IDLE.
- mem_ack in IDLE is ignored.
- Branch:
  - When in_valid & Branch_in & Zero_in is accepted in IDLE: PCSrc = 1 and branch_target = adder_result_in for exactly one cycle.
  - Otherwise PCSrc = 0 and branch_target holds its value.
  - A branch with a memory op is not legal; the memory op is still performed.
- mem_err stays set until reset.
- No arithmetic beyond the counter; the counter saturates and never wraps.

Decomposition:
- A shared package (cpu_pkg) holds:
  - DATA_W, REG_ADDR_W
  - the FSM state encoding (IDLE = 1'b0, ACCESS = 1'b1)
  - the default TIMEOUT_CYCLES
- One natural sub-module, mem_wait_timer: a saturating counter with clear/enable and an expired flag, reused later for the instruction-fetch port.
- WB registers and branch logic stay in the top level.

Test Plan:
- Reset then ALU op: in_valid = 1, RegWrite = 1, ALU_Result_in = 16'h1234, rd = 3 -> next cycle wb_valid = 1, ALU_Result_out = 16'h1234, mux_rd_rt_out = 3, stall never set.
- Load with ack after 3 cycles: addr 16'h0040, mem_rdata = 16'hBEEF -> mem_req held 3 cycles with mem_we = 0, stall = 1 for 2 cycles, read_data_out = 16'hBEEF with wb_valid pulse.
- Store with same-cycle ack: addr 16'h0010, data 16'hA5A5 -> one cycle with mem_req = 1, mem_we = 1, mem_wdata = 16'hA5A5, RegWrite_out = 0, stall = 0.
- Branch taken: Branch = 1, Zero = 1, adder_result = 16'h0020 -> PCSrc = 1 for one cycle, branch_target = 16'h0020; with Zero = 0, PCSrc stays 0.
- Timeout with TIMEOUT_CYCLES = 4 and no ack -> mem_req drops after 4 cycles, mem_err = 1 sticky, RegWrite_out = 0; a later load still succeeds.
- rst_n low during ACCESS -> mem_req = 0 and state IDLE at that edge; mem_ack the next cycle produces no wb_valid.
